// File: rtl/bck_pattern_gen.sv
// bck_pattern_gen: animated background/test-pattern generator, RGB out 2 clk after spot coordinates
// Ports:
//   clk       pixel clock
//   nrst      asynchronous reset, active low
//   spotX     signed current column (blanking when negative or >= HACTIVE)
//   spotY     signed current line   (blanking when negative or >= VACTIVE)
//   mode_req  requested pattern: 0 bars, 1 checker, 2 gradient, 3 grid
//   mode_cur  pattern currently displayed (latched at end of frame)
//   bck_r/g/b background colour components
// Optional feature: define BCK_PATTERN_SCROLL_EN to animate a horizontal scroll
// that advances by SCROLL_STEP every frame; otherwise xs = spotX.
module bck_pattern_gen #(
  parameter int HACTIVE     = 800,
  parameter int VACTIVE     = 600,
  parameter int NBARS       = 8,
  parameter int TILE_LOG2   = 5,
  parameter int SCROLL_STEP = 2,
  parameter int COORD_W     = 11
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic signed [COORD_W-1:0] spotX,
  input  logic signed [COORD_W-1:0] spotY,
  input  logic [1:0]                mode_req,
  output logic [1:0]                mode_cur,
  output logic [7:0]                bck_r,
  output logic [7:0]                bck_g,
  output logic [7:0]                bck_b
);
  localparam logic signed [COORD_W-1:0] HA = COORD_W'(HACTIVE);
  localparam logic signed [COORD_W-1:0] VA = COORD_W'(VACTIVE);
  localparam logic signed [COORD_W-1:0] HL = COORD_W'(HACTIVE - 1);
  localparam logic signed [COORD_W-1:0] VL = COORD_W'(VACTIVE - 1);
  localparam logic [COORD_W:0]          HW = (COORD_W+1)'(HACTIVE);
  localparam logic [COORD_W-1:0]        BW = COORD_W'(HACTIVE / NBARS);
  // 3-bit {r,g,b} on/off masks, entry i at bits [3i+2:3i]:
  // red, green, blue, magenta, yellow, cyan, black, white
  localparam logic [23:0] BAR_LUT = 24'b111_000_011_110_101_001_010_100;

  logic               active, eof;
  logic [COORD_W-1:0] scroll;
  logic [COORD_W:0]   xs_sum;
  logic [COORD_W-1:0] xs_d;
  logic               act_q;
  logic [COORD_W-1:0] xs_q, y_q;
  logic [1:0]         mode_q, mode_cur_q;
  logic [7:0]         fc_q, frame_cnt_q;
  logic [23:0]        rgb_d, rgb_q;
  logic [2:0]         bar_idx, bar;
  logic               checker_on, grid_on;
  logic [7:0]         gr, gg;

  assign active = !spotX[COORD_W-1] && spotX < HA && !spotY[COORD_W-1] && spotY < VA;
  assign eof    = spotX == HL && spotY == VL;

`ifdef BCK_PATTERN_SCROLL_EN
  logic [COORD_W-1:0] scroll_q, scroll_d;
  logic [COORD_W:0]   scroll_sum;
  assign scroll_sum = {1'b0, scroll_q} + (COORD_W+1)'(SCROLL_STEP);
  assign scroll_d   = scroll_sum >= HW ? COORD_W'(scroll_sum - HW) : COORD_W'(scroll_sum);
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) scroll_q <= '0;
    else if (eof) scroll_q <= scroll_d;
  assign scroll = scroll_q;
`else
  assign scroll = '0;
`endif

  // Sum is only meaningful for active pixels, where spotX is non-negative.
  assign xs_sum = {1'b0, spotX} + {1'b0, scroll};
  assign xs_d   = xs_sum >= HW ? COORD_W'(xs_sum - HW) : COORD_W'(xs_sum);

  assign bar_idx    = 3'(xs_q / BW);
  assign bar        = BAR_LUT[3*bar_idx +: 3];
  assign checker_on = xs_q[TILE_LOG2] ^ y_q[TILE_LOG2];
  assign grid_on    = xs_q[TILE_LOG2-1:0] == '0 || y_q[TILE_LOG2-1:0] == '0;
  assign gr         = 8'((32'(xs_q) * 32'd255) / 32'(HACTIVE - 1));
  assign gg         = 8'((32'(y_q) * 32'd255) / 32'(VACTIVE - 1));

  always_comb
    rgb_d = !act_q       ? 24'h000000 :
            mode_q == 0  ? {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}} :
            mode_q == 1  ? {24{checker_on}} :
            mode_q == 2  ? {gr, gg, fc_q} :
            grid_on      ? 24'hFFFFFF : 24'h000040;

  // Stage 1 also captures the frame count so the end-of-frame pixel shows its own frame.
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      act_q       <= 1'b0;
      xs_q        <= '0;
      y_q         <= '0;
      mode_q      <= '0;
      fc_q        <= '0;
      mode_cur_q  <= '0;
      frame_cnt_q <= '0;
      rgb_q       <= '0;
    end else begin
      act_q  <= active;
      xs_q   <= xs_d;
      y_q    <= spotY;
      mode_q <= mode_cur_q;
      fc_q   <= frame_cnt_q;
      rgb_q  <= rgb_d;
      if (eof) begin
        mode_cur_q  <= mode_req;
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
    end

  assign mode_cur = mode_cur_q;
  assign bck_r    = rgb_q[23:16];
  assign bck_g    = rgb_q[15:8];
  assign bck_b    = rgb_q[7:0];
endmodule

// File: tb/tb_bck_pattern_gen.sv
// tb_bck_pattern_gen: scoreboard bench for bck_pattern_gen, directed pixels with hand-computed colours
module tb_bck_pattern_gen;
  localparam int CW = 11;
`ifdef BCK_PATTERN_SCROLL_EN
  localparam bit SCR = 1'b1;
`else
  localparam bit SCR = 1'b0;
`endif
  localparam logic [23:0] RED = 24'hFF0000, GRN = 24'h00FF00, BLU = 24'h0000FF;
  localparam logic [23:0] MAG = 24'hFF00FF, YEL = 24'hFFFF00, CYN = 24'h00FFFF;
  localparam logic [23:0] BLK = 24'h000000, WHT = 24'hFFFFFF, GRD = 24'h000040;

  typedef struct {
    int          due;
    logic [23:0] rgb;
    string       name;
  } exp_t;

  logic               clk = 1'b0;
  logic               nrst = 1'b0;
  logic signed [CW-1:0] spotX = '0, spotY = '0;
  logic [1:0]         mode_req = 2'd0;
  logic [1:0]         mode_cur;
  logic [7:0]         bck_r, bck_g, bck_b;
  int                 cyc = 0, checks = 0, failures = 0, frame = 0;
  exp_t               q[$];

  bck_pattern_gen dut (
    .clk(clk), .nrst(nrst), .spotX(spotX), .spotY(spotY), .mode_req(mode_req),
    .mode_cur(mode_cur), .bck_r(bck_r), .bck_g(bck_g), .bck_b(bck_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%06h required=%06h", n, act, req);
    end
  endtask

  task automatic pix(input int x, input int y, input bit en, input logic [23:0] e, input string n);
    @(negedge clk);
    spotX = CW'(x);
    spotY = CW'(y);
    if (en) q.push_back('{cyc + 2, e, n});
  endtask

  task automatic eof(input bit en, input logic [23:0] e, input string n);
    pix(799, 599, en, e, n);
    pix(0, -1, 1'b0, BLK, "");
    frame++;
  endtask

  task automatic blanks(input int ax, input int ay, input logic [23:0] e, input string n);
    pix(-1, 0, 1'b1, BLK, "blank_xneg");
    pix(800, 0, 1'b1, BLK, "blank_xhi");
    pix(0, 600, 1'b1, BLK, "blank_yhi");
    pix(ax, ay, 1'b1, e, n);
  endtask

  task automatic release_rst();
    @(negedge clk);
    nrst  = 1'b1;
    spotX = '0;
    spotY = '0;
    q.push_back('{cyc + 1, BLK, "post_rst_flush"});
    q.push_back('{cyc + 2, RED, "post_rst_red"});
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        chk(e.name, {bck_r, bck_g, bck_b}, e.rgb);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    spotX = 11'sd10;
    spotY = 11'sd10;
    mode_req = 2'd2;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb", {bck_r, bck_g, bck_b}, BLK);
    chk("rst_mode", mode_cur, 2'd0);
    release_rst();
    // frame 0: bars regardless of the pending request
    pix(100, 0, 1'b1, GRN, "bar1");
    pix(250, 0, 1'b1, BLU, "bar2");
    pix(350, 0, 1'b1, MAG, "bar3");
    pix(450, 0, 1'b1, YEL, "bar4");
    pix(550, 0, 1'b1, CYN, "bar5");
    pix(650, 0, 1'b1, BLK, "bar6");
    pix(799, 0, 1'b1, WHT, "bar7");
    pix(99, 0, 1'b1, RED, "bar0_edge");
    pix(699, 0, 1'b1, BLK, "bar6_edge");
    pix(0, -1, 1'b1, BLK, "blank_yneg");
    blanks(0, 0, RED, "m0_after_blank");
    chk("mode_f0", mode_cur, 2'd0);
    eof(1'b1, WHT, "eof0_old_mode");
    chk("mode_f1", mode_cur, 2'd2);
    // frame 1: gradient
    pix(0, 0, 1'b1, 24'h000001, "grad_f1_org");
    pix(10, 300, 1'b1, 24'h037F01, "grad_f1_mid");
    mode_req = 2'd1;
    pix(0, 599, 1'b1, 24'h00FF01, "grad_f1_bot");
    chk("mode_midreq", mode_cur, 2'd2);
    blanks(0, 0, 24'h000001, "m2_after_blank");
    eof(1'b1, SCR ? 24'h00FF01 : 24'hFFFF01, "eof1_grad");
    chk("mode_f2", mode_cur, 2'd1);
    // frame 2: checker
    pix(32, 0, 1'b1, WHT, "chk_32_0");
    pix(32, 32, 1'b1, BLK, "chk_32_32");
    pix(64, 32, 1'b1, WHT, "chk_64_32");
    pix(0, 0, 1'b1, BLK, "chk_0_0");
    blanks(32, 0, WHT, "m1_after_blank");
    mode_req = 2'd3;
    eof(1'b1, BLK, "eof2_chk");
    chk("mode_f3", mode_cur, 2'd3);
    // frame 3: grid
    pix(0, 0, 1'b1, WHT, "grid_0_0");
    pix(5, 7, 1'b1, GRD, "grid_5_7");
    pix(32, 32, 1'b1, WHT, "grid_32_32");
    pix(26, 3, 1'b1, SCR ? WHT : GRD, "grid_26_3");
    pix(31, 1, 1'b1, GRD, "grid_31_1");
    blanks(0, 0, WHT, "m3_after_blank");
    mode_req = 2'd2;
    eof(1'b1, GRD, "eof3_grid");
    chk("mode_f4", mode_cur, 2'd2);
    eof(1'b0, BLK, "");
    // frame 5: gradient with frame_cnt 5
    pix(0, 0, 1'b1, SCR ? 24'h030005 : 24'h000005, "grad_f5_org");
    mode_req = 2'd0;
    eof(1'b1, SCR ? 24'h02FF05 : 24'hFFFF05, "grad_f5_end");
    chk("mode_f6", mode_cur, 2'd0);
    // frame 6: bars shifted by scroll 12
    pix(88, 0, 1'b1, SCR ? GRN : RED, "scroll_f6_88");
    pix(87, 0, 1'b1, RED, "scroll_f6_87");
    while (frame < 254) eof(1'b0, BLK, "");
    mode_req = 2'd2;
    eof(1'b0, BLK, "");
    pix(0, 0, 1'b1, SCR ? 24'hA200FF : 24'h0000FF, "fcnt_255");
    eof(1'b0, BLK, "");
    pix(0, 0, 1'b1, SCR ? 24'hA30000 : 24'h000000, "fcnt_wrap");
    mode_req = 2'd0;
    while (frame < 399) eof(1'b0, BLK, "");
    // frame 399: scroll 798
    pix(0, 0, 1'b1, SCR ? WHT : RED, "scroll_f399_0");
    pix(2, 0, 1'b1, RED, "scroll_f399_2");
    pix(1, 0, 1'b1, SCR ? WHT : RED, "scroll_f399_1");
    eof(1'b0, BLK, "");
    pix(0, 0, 1'b1, RED, "scroll_wrap_f400");
    mode_req = 2'd3;
    eof(1'b0, BLK, "");
    chk("mode_f401", mode_cur, 2'd3);
    // mid-frame reset
    pix(799, 0, 1'b1, WHT, "pre_rst_a");
    pix(799, 1, 1'b0, GRD, "");
    @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    chk("async_rst_rgb", {bck_r, bck_g, bck_b}, BLK);
    chk("async_rst_mode", mode_cur, 2'd0);
    q.delete();
    release_rst();
    pix(0, -1, 1'b0, BLK, "");
    repeat (4) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
